// File: rtl/disp_arbiter_amisha_pkg.sv
// disp_arbiter_amisha_pkg
// Shared definitions for the two-requester display arbiter: the ownership
// FSM encoding, the hold-counter width and the default decimal-point
// pattern shown while nobody owns the display.
package disp_arbiter_amisha_pkg;

  // Who currently owns the display
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Width of the contested-hold counter
  localparam int HOLD_W = 24;

  // Decimal points driven while the display is unowned (all segments off)
  localparam logic [3:0] IDLE_DP_DEFAULT = 4'b1111;

endpackage

// File: rtl/disp_arbiter_amisha_if.sv
// disp_arbiter_amisha_if
// Bundles the request/data inputs of both requesters and the arbitrated
// display outputs.
//   master : requester side (drives req/hex/dp inputs, sees grant and data)
//   slave  : arbiter side
// Signals:
//   req0_amisha/req1_amisha        level-sensitive display requests
//   hex0_in_amisha/hex1_in_amisha  16-bit digit words, [15:12]=hex3..[3:0]=hex0
//   dp0_in_amisha/dp1_in_amisha    4-bit decimal points per requester
//   gnt_amisha                     one-hot-or-zero grant
//   hex_out_amisha/dp_out_amisha   digits and points toward the hex mux
//   busy_amisha                    high whenever a grant is active
interface disp_arbiter_amisha_if;
  import disp_arbiter_amisha_pkg::*;

  logic        req0_amisha;
  logic        req1_amisha;
  logic [15:0] hex0_in_amisha;
  logic [15:0] hex1_in_amisha;
  logic [3:0]  dp0_in_amisha;
  logic [3:0]  dp1_in_amisha;
  logic [1:0]  gnt_amisha;
  logic [15:0] hex_out_amisha;
  logic [3:0]  dp_out_amisha;
  logic        busy_amisha;

  modport master (
    output req0_amisha, req1_amisha, hex0_in_amisha, hex1_in_amisha,
           dp0_in_amisha, dp1_in_amisha,
    input  gnt_amisha, hex_out_amisha, dp_out_amisha, busy_amisha
  );

  modport slave (
    input  req0_amisha, req1_amisha, hex0_in_amisha, hex1_in_amisha,
           dp0_in_amisha, dp1_in_amisha,
    output gnt_amisha, hex_out_amisha, dp_out_amisha, busy_amisha
  );

endinterface

// File: rtl/disp_arbiter_amisha.sv
// disp_arbiter_amisha
// Arbitrates a single 4-digit hex display between two requesters. A lone
// requester keeps the display as long as it asks; when both ask, the owner
// gets MAX_HOLD cycles before the display moves to the other side. Ties
// from IDLE go to whoever was not served last. All outputs are registered
// and the new owner's data appears on the same edge that raises its grant.
// Ports:
//   clk_amisha    sole clock, rising edge
//   reset_amisha  asynchronous active-high reset
//   bus           slave side of disp_arbiter_amisha_if (requests, data in,
//                 grant, data out, busy)
// Parameters:
//   MAX_HOLD      contested time slice in clock cycles
//   IDLE_DP       dp_out value while the display is unowned
module disp_arbiter_amisha
  import disp_arbiter_amisha_pkg::*;
#(
  parameter logic [HOLD_W-1:0] MAX_HOLD = 24'd5_000_000,
  parameter logic [3:0]        IDLE_DP  = IDLE_DP_DEFAULT
) (
  input logic                   clk_amisha,
  input logic                   reset_amisha,
  disp_arbiter_amisha_if.slave  bus
);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                lp_q, lp_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [15:0]         hex_q, hex_d;
  logic [3:0]          dp_q, dp_d;
  logic                busy_q, busy_d;

  logic                req0, req1;
  logic                holdDone;
  logic                contested;

  assign req0      = bus.req0_amisha;
  assign req1      = bus.req1_amisha;
  assign holdDone  = (cnt_q == MAX_HOLD - 1'b1);
  assign contested = (state_q != IDLE) && req0 && req1;

  // State, hold counter and last-served pointer. lp resets to 1 so that
  // requester 0 wins the very first tie.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
    end
  end

  // Next ownership. Dropping a request hands over directly to a waiting
  // peer with no idle cycle; a contested owner yields once its slice ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = lp_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                 state_d = req1 ? OWN1 : IDLE;
        else if (req1 && holdDone) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                 state_d = req0 ? OWN0 : IDLE;
        else if (req0 && holdDone) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter only runs while the owner is contested and cleared on every
  // ownership change, so it tops out at MAX_HOLD-1 and never wraps.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && contested) cnt_d = cnt_q + HOLD_W'(1);
    lp_d = lp_q;
    if (state_d == OWN0) lp_d = 1'b0;
    if (state_d == OWN1) lp_d = 1'b1;
  end

  // Output values are decoded from the upcoming state so the grant and the
  // new owner's data land on the same edge.
  always_comb begin
    gnt_d  = 2'b00;
    hex_d  = 16'h0000;
    dp_d   = IDLE_DP;
    busy_d = 1'b0;
    case (state_d)
      OWN0: begin
        gnt_d  = 2'b01;
        hex_d  = bus.hex0_in_amisha;
        dp_d   = bus.dp0_in_amisha;
        busy_d = 1'b1;
      end
      OWN1: begin
        gnt_d  = 2'b10;
        hex_d  = bus.hex1_in_amisha;
        dp_d   = bus.dp1_in_amisha;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      gnt_q  <= 2'b00;
      hex_q  <= 16'h0000;
      dp_q   <= IDLE_DP;
      busy_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      hex_q  <= hex_d;
      dp_q   <= dp_d;
      busy_q <= busy_d;
    end
  end

  assign bus.gnt_amisha     = gnt_q;
  assign bus.hex_out_amisha = hex_q;
  assign bus.dp_out_amisha  = dp_q;
  assign bus.busy_amisha    = busy_q;

endmodule

// File: tb/tb_disp_arbiter_amisha.sv
// tb_disp_arbiter_amisha
// Scoreboard bench for disp_arbiter_amisha. Each stimulus cycle runs a
// reference model of display ownership and queues the outputs expected
// after the next rising edge; a monitor pops and compares after each edge.
module tb_disp_arbiter_amisha;
  import disp_arbiter_amisha_pkg::*;

  localparam int         HOLD_CYCLES = 8;
  localparam logic [3:0] IDP         = 4'b1111;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner is -1 (nobody), 0 or 1
  int owner      = -1;
  int lastServed = 1;
  int waited     = 0;

  disp_arbiter_amisha_if bus ();

  disp_arbiter_amisha #(
    .MAX_HOLD (24'(HOLD_CYCLES)),
    .IDLE_DP  (IDP)
  ) dut (
    .clk_amisha   (clk),
    .reset_amisha (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Compares the visible outputs against one expected record
  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = {bus.gnt_amisha, bus.hex_out_amisha, bus.dp_out_amisha, bus.busy_amisha};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got gnt=%b hex=%h dp=%b busy=%b, expected gnt=%b hex=%h dp=%b busy=%b",
               name, $time, a.gnt, a.hex, a.dp, a.busy, e.gnt, e.hex, e.dp, e.busy);
    end
  endtask

  // One clock of the ownership rules, producing the outputs after the edge
  task automatic modelStep(input bit r0, input bit r1,
                           input logic [15:0] h0, input logic [15:0] h1,
                           input logic [3:0] d0, input logic [3:0] d1,
                           output exp_t e);
    int  prev;
    int  other;
    bit  req [2];
    prev   = owner;
    req[0] = r0;
    req[1] = r1;
    if (owner < 0) begin
      if (r0 && r1)  owner = 1 - lastServed;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
    end else begin
      other = 1 - owner;
      if (!req[owner]) begin
        owner = req[other] ? other : -1;
      end else if (req[other]) begin
        waited++;
        if (waited == HOLD_CYCLES) owner = other;
      end
    end
    if (owner != prev || !(r0 && r1)) waited = 0;
    if (owner >= 0 && owner != prev) lastServed = owner;
    if (owner == 0)      e = '{gnt: 2'b01, hex: h0, dp: d0, busy: 1'b1};
    else if (owner == 1) e = '{gnt: 2'b10, hex: h1, dp: d1, busy: 1'b1};
    else                 e = '{gnt: 2'b00, hex: 16'h0000, dp: IDP, busy: 1'b0};
  endtask

  // Drives one cycle of inputs at the falling edge and queues the expectation
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [15:0] h0, input logic [15:0] h1,
                               input logic [3:0] d0, input logic [3:0] d1);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_amisha    = r0;
    bus.req1_amisha    = r1;
    bus.hex0_in_amisha = h0;
    bus.hex1_in_amisha = h1;
    bus.dp0_in_amisha  = d0;
    bus.dp1_in_amisha  = d1;
    modelStep(r0, r1, h0, h1, d0, d1, e);
    expQ.push_back(e);
  endtask

  task automatic randomCycle(input bit r0, input bit r1);
    applyStimulus(r0, r1, 16'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom));
  endtask

  // Asserts reset between edges and checks the outputs respond without a clock
  task automatic doReset();
    exp_t rv;
    rv = '{gnt: 2'b00, hex: 16'h0000, dp: IDP, busy: 1'b0};
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.req0_amisha = 1'b0;
    bus.req1_amisha = 1'b0;
    owner      = -1;
    lastServed = 1;
    waited     = 0;
    #1;
    checkOutput("asyncReset", rv);
    @(posedge clk);
    #1;
    checkOutput("resetHold", rv);
  endtask

  // Monitor: one expectation per edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin
    bit r0, r1;
    rst = 1'b1;
    bus.req0_amisha    = 1'b0;
    bus.req1_amisha    = 1'b0;
    bus.hex0_in_amisha = 16'h0000;
    bus.hex1_in_amisha = 16'h0000;
    bus.dp0_in_amisha  = 4'h0;
    bus.dp1_in_amisha  = 4'h0;
    #1;
    checkOutput("powerOnReset", '{gnt: 2'b00, hex: 16'h0000, dp: IDP, busy: 1'b0});

    // Single requester grant with known data
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'hABCD, 4'b1011, 4'b0000);
    randomCycle(1'b1, 1'b0);
    randomCycle(1'b0, 1'b0);

    // Contested from IDLE after reset: slices alternate every HOLD_CYCLES
    doReset();
    repeat (3 * HOLD_CYCLES + 2) randomCycle(1'b1, 1'b1);

    // Owner drops mid-slice with the peer waiting: direct handover
    doReset();
    repeat (3) randomCycle(1'b1, 1'b1);
    repeat (2) randomCycle(1'b0, 1'b1);

    // Uncontested owner holds indefinitely, then releases to IDLE
    repeat (100) randomCycle(1'b0, 1'b1);
    randomCycle(1'b0, 1'b0);

    // Requester 1 was served last, so a tie now goes to requester 0
    randomCycle(1'b0, 1'b1);
    randomCycle(1'b0, 1'b0);
    repeat (HOLD_CYCLES + 3) randomCycle(1'b1, 1'b1);

    // Reset while requester 1 owns, release with both requesting
    randomCycle(1'b0, 1'b1);
    repeat (3) randomCycle(1'b0, 1'b1);
    doReset();
    repeat (4) randomCycle(1'b1, 1'b1);

    // Random sticky requests so slices and handovers both occur
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) r0 = ~r0;
      if ($urandom_range(0, 9) == 0) r1 = ~r1;
      randomCycle(r0, r1);
      if (i == 250) doReset();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_arbiter_amisha.md
DISP_ARBITER_AMISHA -- requirements
Module: disp_arbiter_amisha

Interface
REQ-001 Parameter MAX_HOLD, default 24'd5_000_000, is the time-slice length in clock cycles when the other requester is waiting.
REQ-002 Parameter IDLE_DP, default 4'b1111, is the dp_out value while no requester owns the display.
REQ-003 clk_amisha  input  1  sole clock, rising edge.
REQ-004 reset_amisha  input  1  asynchronous reset, active-high.
REQ-005 req0_amisha  input  1  requester 0 wants the display.
REQ-006 req1_amisha  input  1  requester 1 wants the display.
REQ-007 hex0_in_amisha  input  16  requester 0 digits: [15:12]=hex3 ... [3:0]=hex0.
REQ-008 hex1_in_amisha  input  16  requester 1 digits, same packing.
REQ-009 dp0_in_amisha  input  4  requester 0 decimal points.
REQ-010 dp1_in_amisha  input  4  requester 1 decimal points.
REQ-011 gnt_amisha  output  2  one-hot-or-zero grant; bit i = requester i owns the display.
REQ-012 hex_out_amisha  output  16  digits to the hex display mux.
REQ-013 dp_out_amisha  output  4  decimal points to the hex display mux.
REQ-014 busy_amisha  output  1  high whenever gnt_amisha is nonzero.

Function
REQ-015 Three-state FSM: IDLE, OWN0, OWN1; gnt_amisha = 00 / 01 / 10 respectively, all outputs registered.
REQ-016 IDLE, only reqN high at edge n -> OWNN and gntN high after edge n (one-cycle grant latency).
REQ-017 IDLE, both requests high -> grant the requester not served last (last-served pointer lp); lp=1 after reset, so requester 0 wins first.
REQ-018 OWNi, reqi dropped -> if other request high go directly to OWN(other), else IDLE; no intervening idle cycle.
REQ-019 OWNi, reqi high, other request low -> stay in OWNi indefinitely; hold counter frozen at 0.
REQ-020 OWNi, reqi high, other request high -> hold counter increments by 1 per cycle; when it equals MAX_HOLD-1, next edge switches to OWN(other) and clears the counter.
REQ-021 Counter is 24 bits, clears on every state change and whenever the other request is low; it never wraps.
REQ-022 lp updates to i on every entry into OWNi.
REQ-023 gnt_amisha never has both bits set, including during OWN0<->OWN1 switches.
REQ-024 Each cycle in OWNi, hex_out_amisha/dp_out_amisha register hexi_in/dpi_in, giving one cycle of data latency relative to the inputs.
REQ-025 The cycle the FSM enters OWNi, hex_out_amisha/dp_out_amisha register the new owner's inputs on the same edge that raises its grant.
REQ-026 In IDLE, hex_out_amisha = 16'h0000 and dp_out_amisha = IDLE_DP.
REQ-027 Requests are level-sensitive; a requester not granted must hold its request high, and the block stores no pending requests.

Reset
REQ-028 reset_amisha high forces immediately, without waiting for a clock edge: state IDLE, gnt_amisha=00, busy_amisha=0, hex_out_amisha=16'h0000, dp_out_amisha=IDLE_DP, counter=0, lp=1.
REQ-029 Reset asserted mid-ownership drops the grant immediately; after release, arbitration restarts from IDLE using REQ-016/017.
REQ-030 The first grant may occur on the first rising edge after reset_amisha deasserts.

Structure
REQ-031 A shared package holds the FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), HOLD_W=24, and the default IDLE_DP.
REQ-032 The block is a single module with no sub-modules; its outputs connect directly to the hex3..hex0 and dp_in inputs of disp_hex_mux_Amisha.

Verification (bench uses MAX_HOLD=8, IDLE_DP=4'b1111)
REQ-033 Reset, then req0=1 with hex0_in=16'h1234, dp0=4'b1011 -> next edge: gnt=01, hex_out=1234, dp_out=1011, busy=1.
REQ-034 Both requests raised together from IDLE after reset -> gnt=01; exactly 8 cycles later gnt=10; 8 cycles after that gnt=01 again; never 11.
REQ-035 OWN0 with req1 high, req0 dropped at cycle 3 of the hold -> next edge gnt=10 and hex_out=hex1_in; no idle cycle.
REQ-036 OWN1 with req0 low, hold for 100 cycles -> gnt stays 10 and counter stays 0; then drop req1 -> gnt=00, hex_out=0000, dp_out=1111.
REQ-037 Assert reset_amisha between clock edges while gnt=10 -> gnt=00 and outputs at their reset values before the next edge; release with both requests high -> gnt=01 first.
REQ-038 Last-served check: serve req1 alone, release it, then raise both requests together -> gnt=01.
